spi_sample_tx: RTL and testbench
================================

SPI_SAMPLE_TX -- requirements
Module: spi_sample_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 10, giving the sample word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the FIFO depth in words; DEPTH SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchroniser flops for cs_i and sclk_i; SYNC_STAGES SHALL be at least 2.
REQ-004 main_clk  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 data_i  in  DATA_W  sample word, synchronous to main_clk.
REQ-007 valid_i  in  1  write strobe: data_i is offered on every main_clk cycle in which valid_i is high.
REQ-008 cs_i  in  1  SPI chip select, active-low, asynchronous to main_clk.
REQ-009 sclk_i  in  1  SPI clock (mode 0), asynchronous to main_clk.
REQ-010 sdo_o  out  1  SPI serial data out, driven from a register.
REQ-011 level_o  out  $clog2(DEPTH+1)  FIFO occupancy in words.
REQ-012 overflow_o  out  1  sticky flag: a sample was dropped.
REQ-013 busy_o  out  1  high while a frame is loaded or shifting.

Function
REQ-014 cs_i and sclk_i SHALL each pass through a SYNC_STAGES flop chain; edges SHALL be detected on the last stage; main_clk SHALL be at least 8x the sclk_i frequency.
REQ-015 The FIFO SHALL accept a word when valid_i is high and level_o is below DEPTH; level_o SHALL increase by 1 on the next cycle.
REQ-016 Fullness SHALL be evaluated before any pop in the same cycle; a valid_i while level_o equals DEPTH SHALL drop the word and set overflow_o on the next cycle, even if a pop occurs in that cycle.
REQ-017 A push and a pop in the same cycle SHALL both take effect, leaving level_o unchanged.
REQ-018 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-019 overflow_o SHALL clear on the cycle after a synchronised cs falling edge, unless a drop occurs in that same cycle; a drop SHALL take priority.
REQ-020 The state machine SHALL have three states: IDLE, LOAD and SHIFT.
REQ-021 IDLE: sdo_o SHALL be 0 and busy_o SHALL be 0; on a synchronised cs falling edge the next state SHALL be LOAD.
REQ-022 LOAD, one cycle: if level_o > 0, the block SHALL pop the oldest word into the shift register and set the header bit to 1.
REQ-023 LOAD with level_o = 0: the block SHALL load a zero word and set the header bit to 0; no pop SHALL occur.
REQ-024 In LOAD, sdo_o SHALL take the header bit, busy_o SHALL go to 1, the bit counter SHALL clear, and the next state SHALL be SHIFT.
REQ-025 Frame order SHALL be: header bit, then the data bits MSB first, then (per REQ-033) the parity bit; F is the frame length in bits.
REQ-026 SHIFT: on each synchronised sclk falling edge, sdo_o SHALL advance to the next frame bit.
REQ-027 After the F-1 advances that present the last frame bit, any further sclk falling edge SHALL drive sdo_o to 0 and hold it there.
REQ-028 sclk rising edges SHALL NOT change state.
REQ-029 A synchronised cs rising edge in LOAD or SHIFT SHALL return the block to IDLE on the next cycle, with sdo_o = 0 and busy_o = 0.
REQ-030 A word popped in an aborted frame SHALL be discarded, not re-queued.
REQ-031 The header bit SHALL appear on sdo_o no later than SYNC_STAGES+2 main_clk cycles after cs_i falls.

Reset
REQ-032 While rst is high, the block SHALL hold: state IDLE, FIFO pointers 0, level_o 0, overflow_o 0, busy_o 0, sdo_o 0, shift register 0, bit counter 0, and synchroniser flops at 1 for cs and 0 for sclk. Reset asserted mid-frame SHALL abort the frame and empty the FIFO.

Configuration
REQ-033 Macro SPI_TX_PARITY_EN: when defined, the block SHALL append an even-parity bit (XOR of the DATA_W data bits, 0 for an empty frame), so F = DATA_W+2. When not defined, no parity bit SHALL be sent and F = DATA_W+1.

Verification
REQ-034 Push 10'h2A5, then run a 12-clock frame with parity enabled -> sdo_o sequence 1,1,0,1,0,1,0,0,1,0,1,1 (the last bit is parity of 5 ones = 1); level_o goes 1 to 0.
REQ-035 Run a frame with the FIFO empty -> all frame bits 0, no pop, level_o stays 0.
REQ-036 Push 9 words with DEPTH=8 -> level_o = 8 and overflow_o = 1; the next frame returns the first word and overflow_o clears after cs falls.
REQ-037 Hold level_o at 8, then assert valid_i in the LOAD pop cycle -> the word is dropped, overflow_o = 1, and level_o becomes 7.
REQ-038 Raise cs_i after 4 sclk cycles, then start a new frame -> sdo_o returns to 0 and the second frame carries the next word; the first word is lost.
REQ-039 Assert rst mid-frame with level_o = 5 -> all outputs 0 while rst is high; after release, an empty frame reads header bit 0.

Source files
------------

// File: rtl/spi_sample_tx.sv
// SPI mode-0 slave transmitter fed from a sample FIFO. Frame: header, data MSB first,
// optional even-parity bit (define SPI_TX_PARITY_EN to enable it).
module spi_sample_tx #(
   parameter int unsigned DATA_W      = 10,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       main_clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          data_i,
   input  logic                       valid_i,
   input  logic                       cs_i,
   input  logic                       sclk_i,
   output logic                       sdo_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       overflow_o,
   output logic                       busy_o
);

   localparam int unsigned LvlW = $clog2(DEPTH + 1);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DATA_W + 2);
`ifdef SPI_TX_PARITY_EN
   localparam int unsigned FrameLen = DATA_W + 2;
`else
   localparam int unsigned FrameLen = DATA_W + 1;
`endif
   localparam logic [CntW-1:0] LastIdx = CntW'(FrameLen - 1);
   localparam logic [CntW-1:0] DataEnd = CntW'(DATA_W);
   localparam logic [LvlW-1:0] Full    = LvlW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic                   cs_prev_q, cs_prev_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]        level_q, level_d;
   logic                   overflow_q, overflow_d;
   logic                   sdo_q, sdo_d;
   logic [DATA_W-1:0]      sr_q, sr_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
`ifdef SPI_TX_PARITY_EN
   logic                   par_q, par_d;
`endif
   logic [DATA_W-1:0]      mem_q [DEPTH];

   logic cs_fall, cs_rise, sclk_fall;
   logic push, pop, drop;
   logic [DATA_W-1:0] load_word;

   always_comb begin
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_i};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
      sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
      cs_fall     = cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
      cs_rise     = ~cs_prev_q & cs_sync_q[SYNC_STAGES-1];
      sclk_fall   = sclk_prev_q & ~sclk_sync_q[SYNC_STAGES-1];
   end

   // Fullness is judged on the registered level, so a same-cycle pop cannot rescue a push.
   always_comb begin
      push     = valid_i & (level_q != Full);
      drop     = valid_i & (level_q == Full);
      pop      = (state_q == StLoad) & (level_q != '0);
      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (push && !pop) begin
         level_d = level_q + LvlW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LvlW'(1);
      end
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (cs_fall) begin
         overflow_d = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      sdo_d     = sdo_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
`ifdef SPI_TX_PARITY_EN
      par_d     = par_q;
`endif
      load_word = pop ? mem_q[rd_ptr_q] : '0;
      unique case (state_q)
         StIdle: begin
            sdo_d = 1'b0;
            if (cs_fall) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            sr_d    = load_word;
            sdo_d   = pop;
            cnt_d   = '0;
`ifdef SPI_TX_PARITY_EN
            par_d   = ^load_word;
`endif
            state_d = StShift;
            if (cs_rise) begin
               state_d = StIdle;
               sdo_d   = 1'b0;
            end
         end
         StShift: begin
            if (cs_rise) begin
               state_d = StIdle;
               sdo_d   = 1'b0;
            end else if (sclk_fall) begin
               // Counter saturates on the last frame bit; later edges just hold sdo low.
               if (cnt_q != LastIdx) begin
                  cnt_d = cnt_q + CntW'(1);
                  if (cnt_q < DataEnd) begin
                     sdo_d = sr_q[DATA_W-1];
                     sr_d  = sr_q << 1;
                  end else begin
`ifdef SPI_TX_PARITY_EN
                     sdo_d = par_q;
`else
                     sdo_d = 1'b0;
`endif
                  end
               end else begin
                  sdo_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = StIdle;
            sdo_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge main_clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cs_sync_q   <= '1;
         sclk_sync_q <= '0;
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         sdo_q       <= 1'b0;
         sr_q        <= '0;
         cnt_q       <= '0;
`ifdef SPI_TX_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cs_sync_q   <= cs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         cs_prev_q   <= cs_prev_d;
         sclk_prev_q <= sclk_prev_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         sdo_q       <= sdo_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
`ifdef SPI_TX_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   always_ff @(posedge main_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign sdo_o      = sdo_q;
   assign level_o    = level_q;
   assign overflow_o = overflow_q;
   assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_spi_sample_tx.sv
// Bench for spi_sample_tx: table of sample words with hand-derived frames, scoreboard queue
// of expected frames, plus sequences for overflow, LOAD-cycle drop, abort and mid-frame reset.
module tb_spi_sample_tx;

`ifdef SPI_TX_PARITY_EN
   localparam int F = 12;
`else
   localparam int F = 11;
`endif

   logic       main_clk = 1'b0;
   logic       rst;
   logic [9:0] data_i;
   logic       valid_i;
   logic       cs_i;
   logic       sclk_i;
   logic       sdo_o;
   logic [3:0] level_o;
   logic       overflow_o;
   logic       busy_o;

   spi_sample_tx dut (
      .main_clk   (main_clk),
      .rst        (rst),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .cs_i       (cs_i),
      .sclk_i     (sclk_i),
      .sdo_o      (sdo_o),
      .level_o    (level_o),
      .overflow_o (overflow_o),
      .busy_o     (busy_o)
   );

   always #5 main_clk = ~main_clk;

   typedef struct {
      logic [9:0]  data;
      logic [11:0] frame;  // {header, data MSB first, even parity}
   } vec_t;

   vec_t        vecs [5];
   logic [11:0] sb_q [$];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] frame_of(input logic [9:0] d);
      return {1'b1, d, ^d};
   endfunction

   task automatic push(input logic [9:0] w);
      @(negedge main_clk);
      data_i  = w;
      valid_i = 1'b1;
      @(negedge main_clk);
      valid_i = 1'b0;
   endtask

   task automatic cs_fall();
      @(negedge main_clk);
      cs_i = 1'b0;
      repeat (6) @(negedge main_clk);
   endtask

   task automatic cs_rise();
      @(negedge main_clk);
      cs_i = 1'b1;
      repeat (6) @(negedge main_clk);
   endtask

   task automatic sclk_cycle();
      @(negedge main_clk);
      sclk_i = 1'b1;
      repeat (8) @(negedge main_clk);
      sclk_i = 1'b0;
      repeat (8) @(negedge main_clk);
   endtask

   // Header check, then nadv falling sclk edges; bits beyond the frame must read 0.
   task automatic frame_bits(input logic [11:0] exp, input int nadv, input string tag);
      check({tag, "_hdr"}, sdo_o, exp[11]);
      check({tag, "_busy"}, busy_o, 1'b1);
      for (int k = 1; k <= nadv; k++) begin
         sclk_cycle();
         check($sformatf("%s_bit%0d", tag, k), sdo_o, (k < F) ? exp[11-k] : 1'b0);
      end
   endtask

   initial begin
      vecs[0] = '{data: 10'h2A5, frame: 12'b1_10_1010_0101_1};
      vecs[1] = '{data: 10'h3FF, frame: 12'b1_11_1111_1111_0};
      vecs[2] = '{data: 10'h001, frame: 12'b1_00_0000_0001_1};
      vecs[3] = '{data: 10'h200, frame: 12'b1_10_0000_0000_1};
      vecs[4] = '{data: 10'h0CC, frame: 12'b1_00_1100_1100_0};

      rst = 1'b1; data_i = '0; valid_i = 1'b0; cs_i = 1'b1; sclk_i = 1'b0;
      repeat (3) @(negedge main_clk);
      check("rst_sdo", sdo_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_level", level_o, 4'd0);
      check("rst_ovf", overflow_o, 1'b0);
      rst = 1'b0;
      repeat (4) @(negedge main_clk);

      // Table: fill FIFO, then drain one frame per entry in order.
      for (int i = 0; i < 5; i++) begin
         push(vecs[i].data);
         sb_q.push_back(vecs[i].frame);
         check("tbl_level_push", level_o, 32'(sb_q.size()));
      end
      for (int i = 0; i < 5; i++) begin
         cs_fall();
         frame_bits(sb_q.pop_front(), F, $sformatf("tbl%0d", i));
         check("tbl_level_pop", level_o, 32'(sb_q.size()));
         cs_rise();
         check("tbl_idle_sdo", sdo_o, 1'b0);
         check("tbl_idle_busy", busy_o, 1'b0);
      end

      // Empty FIFO: all-zero frame, no pop.
      cs_fall();
      frame_bits(12'h000, F, "empty");
      check("empty_level", level_o, 4'd0);
      cs_rise();

      // Nine pushes into an 8-deep FIFO; ninth is dropped.
      for (int i = 0; i < 9; i++) begin
         logic [9:0] w;
         w = 10'(i * 37 + 3);
         push(w);
         if (sb_q.size() < 8) sb_q.push_back(frame_of(w));
      end
      check("ovf_level", level_o, 4'd8);
      check("ovf_flag", overflow_o, 1'b1);
      cs_fall();
      check("ovf_clear", overflow_o, 1'b0);
      frame_bits(sb_q.pop_front(), F, "ovf");
      cs_rise();
      check("ovf_level_after", level_o, 4'd7);

      // Refill to 8, then offer a word exactly in the LOAD pop cycle.
      push(10'h155);
      sb_q.push_back(frame_of(10'h155));
      check("ld_level_full", level_o, 4'd8);
      @(negedge main_clk);
      cs_i = 1'b0;
      repeat (2) @(negedge main_clk);
      check("ld_busy_pre", busy_o, 1'b0);
      @(negedge main_clk);
      check("ld_busy_load", busy_o, 1'b1);
      data_i  = 10'h3C3;
      valid_i = 1'b1;
      @(negedge main_clk);
      valid_i = 1'b0;
      check("ld_level", level_o, 4'd7);
      check("ld_ovf", overflow_o, 1'b1);
      repeat (2) @(negedge main_clk);
      frame_bits(sb_q.pop_front(), F, "ld");
      cs_rise();

      // Abort after 4 sclk cycles; popped word is lost.
      cs_fall();
      frame_bits(sb_q.pop_front(), 4, "abort");
      cs_rise();
      check("abort_sdo", sdo_o, 1'b0);
      check("abort_busy", busy_o, 1'b0);
      cs_fall();
      frame_bits(sb_q.pop_front(), F, "next");
      cs_rise();
      check("next_level", level_o, 32'(sb_q.size()));
      check("next_level5", level_o, 4'd5);

      // Reset mid-frame: everything clears and the FIFO empties.
      cs_fall();
      sclk_cycle();
      sclk_cycle();
      @(negedge main_clk);
      rst = 1'b1; cs_i = 1'b1; sclk_i = 1'b0;
      @(negedge main_clk);
      check("mrst_sdo", sdo_o, 1'b0);
      check("mrst_busy", busy_o, 1'b0);
      check("mrst_level", level_o, 4'd0);
      check("mrst_ovf", overflow_o, 1'b0);
      repeat (3) @(negedge main_clk);
      rst = 1'b0;
      sb_q.delete();
      repeat (4) @(negedge main_clk);
      cs_fall();
      frame_bits(12'h000, F, "post_rst");
      check("post_rst_level", level_o, 4'd0);
      cs_rise();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
